// File: rtl/aes_pkg.sv
// aes_pkg: shared types, widths and GF(2^8)/round helpers for the AES mode engine
package aes_pkg;
  localparam int KEY_SIZE = 128;
  localparam int BLOCK_W = 128;
  typedef enum logic [2:0] {ECB = 3'd0, CBC = 3'd1, CFB = 3'd2, OFB = 3'd3, CTR = 3'd4} mode_e;
  typedef enum logic [1:0] {UNCFG, IDLE, BUSY} state_e;
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      p ^= b[i] ? t : 8'h00;
      t = xtime(t);
    end
    return p;
  endfunction
  // inverse as x^254 (product of x^2..x^128), then the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, inv, t, r;
    sq = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    t = inv;
    r = inv;
    for (int i = 0; i < 4; i++) begin
      t = {t[6:0], t[7]};
      r ^= t;
    end
    return r ^ 8'h63;
  endfunction
  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction
  // byte i of the block is bits [127-8i -: 8]; column-major, i = 4*col + row
  function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] rk, input logic last);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) b[i] = sbox(st[127-8*i -: 8]);
    for (int i = 0; i < 16; i++) t[i] = b[(i + 4 * (i % 4)) % 16];
    for (int c = 0; c < 4; c++) begin
      a0 = t[4*c];
      a1 = t[4*c+1];
      a2 = t[4*c+2];
      a3 = t[4*c+3];
      r[127-32*c -: 32] = last ? {a0, a1, a2, a3} :
        {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3, a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
         a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3, xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return r ^ rk;
  endfunction
endpackage

// File: rtl/aes_cipher.sv
// aes_cipher: forward AES core, one round per pipeline stage, latency NR+1, whole-pipe stall
// ports: key_i/key_valid_i/key_ready_o key load (expands one word per cycle),
//        din_i/din_valid_i/din_ready_o plaintext in, dout_o/dout_valid_o/dout_ready_i E(din) out
module aes_cipher
  import aes_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [KEY_SIZE-1:0] key_i,
  input  logic                key_valid_i,
  output logic                key_ready_o,
  input  logic [BLOCK_W-1:0]  din_i,
  input  logic                din_valid_i,
  output logic                din_ready_o,
  output logic [BLOCK_W-1:0]  dout_o,
  output logic                dout_valid_o,
  input  logic                dout_ready_i
);
  localparam int NK = KEY_SIZE / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
  logic [31:0] w [NW];
  logic [BLOCK_W-1:0] rkey [NR+1];
  logic [BLOCK_W-1:0] s [NR+1];
  logic [NR:0] v;
  logic [5:0] idx;
  logic [2:0] kc;
  logic [7:0] rcon;
  logic expanding, keyed, adv;
  logic [31:0] prev, temp;
  for (genvar g = 0; g <= NR; g++) begin : g_rk
    assign rkey[g] = {w[4*g], w[4*g+1], w[4*g+2], w[4*g+3]};
  end
  assign prev = w[idx - 6'd1];
  assign temp = kc == 3'd0 ? sub_word({prev[23:0], prev[31:24]}) ^ {rcon, 24'h0} :
                (NK > 6 && kc == 3'd4) ? sub_word(prev) : prev;
  assign key_ready_o = !expanding;
  assign adv = !v[NR] || dout_ready_i;
  assign din_ready_o = keyed && adv;
  assign dout_o = s[NR];
  assign dout_valid_o = v[NR];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NW; i++) w[i] <= '0;
      idx <= '0;
      kc <= '0;
      rcon <= 8'h01;
      expanding <= 1'b0;
      keyed <= 1'b0;
    end else if (key_valid_i && key_ready_o) begin
      for (int i = 0; i < NK; i++) w[i] <= key_i[KEY_SIZE-1-32*i -: 32];
      idx <= 6'(NK);
      kc <= '0;
      rcon <= 8'h01;
      expanding <= 1'b1;
      keyed <= 1'b0;
    end else if (expanding) begin
      w[idx] <= w[idx - 6'(NK)] ^ temp;
      idx <= idx + 6'd1;
      kc <= kc == 3'(NK - 1) ? 3'd0 : kc + 3'd1;
      if (kc == 3'd0) rcon <= xtime(rcon);
      if (idx == 6'(NW - 1)) begin
        expanding <= 1'b0;
        keyed <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      for (int k = 0; k <= NR; k++) s[k] <= '0;
    end else if (adv) begin
      v <= {v[NR-1:0], din_valid_i && din_ready_o};
      s[0] <= din_i ^ rkey[0];
      for (int k = 1; k <= NR; k++) s[k] <= aes_round(s[k-1], rkey[k], k == NR);
    end
  end
endmodule

// File: rtl/aes_mode_fifo.sv
// aes_mode_fifo: DEPTH-entry plaintext FIFO; head visible on dout, occupancy on count
module aes_mode_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 128
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign dout = mem[rp];
  assign full = count == CW'(DEPTH);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) mem[wp] <= din;
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/aes_mode_engine.sv
// aes_mode_engine: ECB/CBC/CFB/OFB/CTR block-cipher modes around aes_cipher over valid/ready streams
// ports: key_* key load passthrough, mode_i/decrypt_i/iv_i/iv_valid_i/iv_ready_o configuration,
//        din_* input blocks, dout_* registered result blocks
module aes_mode_engine
  import aes_pkg::*;
#(
  parameter int CTR_WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [KEY_SIZE-1:0] key_i,
  input  logic                key_valid_i,
  output logic                key_ready_o,
  input  logic [2:0]          mode_i,
  input  logic                decrypt_i,
  input  logic [BLOCK_W-1:0]  iv_i,
  input  logic                iv_valid_i,
  output logic                iv_ready_o,
  input  logic [BLOCK_W-1:0]  din_i,
  input  logic                din_valid_i,
  output logic                din_ready_o,
  output logic [BLOCK_W-1:0]  dout_o,
  output logic                dout_valid_o,
  input  logic                dout_ready_i
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_e state;
  mode_e mode;
  logic dec, cfg, load, push, pop, full, pipe, fb_upd, busy_n;
  logic c_din_ready, c_dout_valid;
  logic [BLOCK_W-1:0] v, x, c_din, c_dout, res, ctr_mask, v_ctr;
  logic [CW-1:0] cnt;
  assign cfg = iv_valid_i && iv_ready_o;
  assign iv_ready_o = state != BUSY;
  assign load = !dout_valid_o || dout_ready_i;
  assign pop = c_dout_valid && load;
  assign pipe = mode == ECB || mode == CTR;
  assign din_ready_o = state != UNCFG && c_din_ready && !full && (pipe || cnt == '0);
  assign push = din_valid_i && din_ready_o;
  assign busy_n = cnt + CW'(push) != CW'(pop);
  assign c_din = mode == ECB ? din_i : mode == CBC ? din_i ^ v : v;
  assign res = (mode == ECB || mode == CBC) ? c_dout : c_dout ^ x;
  assign fb_upd = mode == CBC || mode == OFB || (mode == CFB && !dec);
  // only the low CTR_WIDTH bits count; the mask form also covers CTR_WIDTH=128
  assign ctr_mask = {BLOCK_W{1'b1}} >> (BLOCK_W - CTR_WIDTH);
  assign v_ctr = (v & ~ctr_mask) | ((v + BLOCK_W'(1)) & ctr_mask);
  aes_cipher u_core (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_i        (key_i),
    .key_valid_i  (key_valid_i && state != BUSY),
    .key_ready_o  (key_ready_o),
    .din_i        (c_din),
    .din_valid_i  (push),
    .din_ready_o  (c_din_ready),
    .dout_o       (c_dout),
    .dout_valid_o (c_dout_valid),
    .dout_ready_i (load)
  );
  aes_mode_fifo #(.DEPTH(DEPTH), .W(BLOCK_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (din_i),
    .pop   (pop),
    .dout  (x),
    .count (cnt),
    .full  (full)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= UNCFG;
      mode <= ECB;
      dec <= 1'b0;
      v <= '0;
      dout_o <= '0;
      dout_valid_o <= 1'b0;
    end else begin
      state <= (state == UNCFG && !cfg) ? UNCFG : (push || busy_n) ? BUSY : IDLE;
      if (cfg) begin
        mode <= mode_i > 3'd4 ? ECB : mode_e'(mode_i);
        dec <= decrypt_i;
      end
      if (cfg) v <= iv_i;
      else if (push && mode == CTR) v <= v_ctr;
      else if (push && mode == CFB && dec) v <= din_i;
      else if (pop && fb_upd) v <= mode == OFB ? c_dout : res;
      if (load) begin
        dout_valid_o <= c_dout_valid;
        if (c_dout_valid) dout_o <= res;
      end
    end
  end
endmodule

// File: tb/tb_aes_mode_engine.sv
// tb_aes_mode_engine: scoreboard bench with SP800-38A vectors for all modes
module tb_aes_mode_engine;
  import aes_pkg::*;
  localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] IVC = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] P [4] = '{128'h6bc1bee22e409f96e93d7e117393172a, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
                                     128'h30c81c46a35ce411e5fbc1191a0a52ef, 128'hf69f2445df4f9b17ad2b417be66c3710};
  localparam logic [127:0] ECB_C [4] = '{128'h3ad77bb40d7a3660a89ecaf32466ef97, 128'hf5d3d58503b9699de785895a96fdbaaf,
                                         128'h43b1cd7f598ece23881b00e3ed030688, 128'h7b0c785e27e8ad3f8223207104725dd4};
  localparam logic [127:0] CBC_C [4] = '{128'h7649abac8119b246cee98e9b12e9197d, 128'h5086cb9b507219ee95db113a917678b2,
                                         128'h73bed6b8e3c1743b7116e69e22229516, 128'h3ff1caa1681fac09120eca307586e1a7};
  localparam logic [127:0] CFB_C [4] = '{128'h3b3fd92eb72dad20333449f8e83cfb4a, 128'hc8a64537a0b3a93fcde3cdad9f1ce58b,
                                         128'h26751f67a3cbb140b1808cf187a4f4df, 128'hc04b05357c5d1c0eeac4c66f9ff7f2e6};
  localparam logic [127:0] OFB_C [4] = '{128'h3b3fd92eb72dad20333449f8e83cfb4a, 128'h7789508d16918f03f53c52dac54ed825,
                                         128'h9740051e9c5fecf64344f7a82260edcc, 128'h304c6528f659c77866a510d9c1d6ae5e};
  localparam logic [127:0] CTR_C [4] = '{128'h874d6191b620e3261bef6864990db6ce, 128'h9806f66b7970fdff8617187bb9fffdff,
                                         128'h5ae4df3edbd5d35e5b4f09020db03eab, 128'h1e031dda2fbe03d1792170a0f3009cee};
  logic clk = 1'b0, rst_n = 1'b0;
  logic [127:0] key_i = '0, iv_i = '0, din_i = '0;
  logic key_valid_i = 1'b0, iv_valid_i = 1'b0, din_valid_i = 1'b0, decrypt_i = 1'b0, dout_ready_i = 1'b1;
  logic [2:0] mode_i = 3'd0;
  logic key_ready_o, iv_ready_o, din_ready_o, dout_valid_o;
  logic [127:0] dout_o;
  logic [127:0] sb [$];
  int n_pass = 0, n_total = 0;
  bit bp = 1'b0;
  aes_mode_engine dut (
    .clk(clk), .rst_n(rst_n), .key_i(key_i), .key_valid_i(key_valid_i), .key_ready_o(key_ready_o),
    .mode_i(mode_i), .decrypt_i(decrypt_i), .iv_i(iv_i), .iv_valid_i(iv_valid_i), .iv_ready_o(iv_ready_o),
    .din_i(din_i), .din_valid_i(din_valid_i), .din_ready_o(din_ready_o),
    .dout_o(dout_o), .dout_valid_o(dout_valid_o), .dout_ready_i(dout_ready_i)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = t[7] ? ((t << 1) ^ 8'h1b) : (t << 1);
    end
    return p;
  endfunction
  function automatic logic [7:0] ref_sbox(input logic [7:0] x);
    logic [7:0] inv, s, c;
    inv = 8'h00;
    c = 8'h63;
    for (int y = 1; y < 256; y++) if (ref_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
    for (int i = 0; i < 8; i++)
      s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
    return s;
  endfunction
  function automatic logic [127:0] ref_enc(input logic [127:0] key, input logic [127:0] blk);
    logic [31:0] w [44];
    logic [7:0] st [16];
    logic [7:0] t [16];
    logic [7:0] rc, a0, a1, a2, a3;
    logic [31:0] tmp;
    logic [127:0] r;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {ref_sbox(tmp[23:16]), ref_sbox(tmp[15:8]), ref_sbox(tmp[7:0]), ref_sbox(tmp[31:24])} ^ {rc, 24'h0};
        rc = ref_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) st[i] = blk[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rn = 1; rn <= 10; rn++) begin
      for (int i = 0; i < 16; i++) t[i] = ref_sbox(st[(i + 4*(i%4)) % 16]);
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (rn < 10) begin
          st[4*c]   = ref_mul(a0, 8'h02) ^ ref_mul(a1, 8'h03) ^ a2 ^ a3;
          st[4*c+1] = a0 ^ ref_mul(a1, 8'h02) ^ ref_mul(a2, 8'h03) ^ a3;
          st[4*c+2] = a0 ^ a1 ^ ref_mul(a2, 8'h02) ^ ref_mul(a3, 8'h03);
          st[4*c+3] = ref_mul(a0, 8'h03) ^ a1 ^ a2 ^ ref_mul(a3, 8'h02);
        end else begin
          st[4*c] = a0; st[4*c+1] = a1; st[4*c+2] = a2; st[4*c+3] = a3;
        end
        for (int k = 0; k < 4; k++) st[4*c+k] = st[4*c+k] ^ w[4*rn+c][31-8*k -: 8];
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = st[i];
    return r;
  endfunction
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic bad(input string name);
    n_total++;
    $display("FAIL %s: timed out or unexpected event", name);
  endtask
  task automatic load_key(input logic [127:0] k);
    int n = 0;
    key_i = k;
    key_valid_i = 1'b1;
    do begin @(negedge clk); n++; end while (!key_ready_o && n < 200);
    if (!key_ready_o) bad("key_load");
    @(posedge clk); #1 key_valid_i = 1'b0;
  endtask
  task automatic config_iv(input logic [2:0] m, input logic d, input logic [127:0] iv);
    int n = 0;
    mode_i = m;
    decrypt_i = d;
    iv_i = iv;
    iv_valid_i = 1'b1;
    do begin @(negedge clk); n++; end while (!iv_ready_o && n < 300);
    if (!iv_ready_o) bad("iv_config");
    @(posedge clk); #1 iv_valid_i = 1'b0;
  endtask
  task automatic send(input logic [127:0] x, input logic [127:0] exp, input bit track);
    int n = 0;
    din_i = x;
    din_valid_i = 1'b1;
    if (track) sb.push_back(exp);
    do begin @(negedge clk); n++; end while (!din_ready_o && n < 300);
    if (!din_ready_o) bad("din_accept");
    @(posedge clk); #1 din_valid_i = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 600) begin @(negedge clk); n++; end
    if (sb.size() != 0) bad("drain");
    repeat (3) @(negedge clk);
  endtask
  initial forever begin
    @(posedge clk);
    #1 dout_ready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  initial begin
    logic [127:0] held;
    bit stall;
    stall = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) stall = 1'b0;
      else begin
        if (stall) begin
          chk("hold_valid", 128'(dout_valid_o), 128'd1);
          chk("hold_data", dout_o, held);
        end
        stall = dout_valid_o && !dout_ready_i;
        held = dout_o;
        if (dout_valid_o && dout_ready_i) begin
          if (sb.size() == 0) bad("unexpected_output");
          else chk("dout", dout_o, sb.pop_front());
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [127:0] w1, w2, e1, e2;
    repeat (3) @(negedge clk);
    chk("rst_dout", dout_o, 128'd0);
    chk("rst_dout_valid", 128'(dout_valid_o), 128'd0);
    chk("rst_din_ready", 128'(din_ready_o), 128'd0);
    chk("rst_iv_ready", 128'(iv_ready_o), 128'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    load_key(KEY);
    config_iv(3'd0, 1'b0, '0);
    for (int i = 0; i < 4; i++) send(P[i], ECB_C[i], 1'b1);
    drain();
    config_iv(3'd1, 1'b0, IV0);
    send(P[0], CBC_C[0], 1'b1);
    @(negedge clk);
    chk("cbc_din_ready_low", 128'(din_ready_o), 128'd0);
    for (int i = 1; i < 4; i++) send(P[i], CBC_C[i], 1'b1);
    drain();
    config_iv(3'd3, 1'b0, IV0);
    for (int i = 0; i < 4; i++) send(P[i], OFB_C[i], 1'b1);
    drain();
    config_iv(3'd2, 1'b0, IV0);
    for (int i = 0; i < 4; i++) send(P[i], CFB_C[i], 1'b1);
    drain();
    config_iv(3'd2, 1'b1, IV0);
    for (int i = 0; i < 4; i++) send(CFB_C[i], P[i], 1'b1);
    drain();
    bp = 1'b1;
    config_iv(3'd4, 1'b0, IVC);
    for (int i = 0; i < 4; i++) send(P[i], CTR_C[i], 1'b1);
    drain();
    bp = 1'b0;
    w1 = 128'hf0f1f2f3f4f5f6f7f8f9fafbffffffff;
    w2 = {w1[127:32], 32'h00000000};
    e1 = ref_enc(KEY, w1) ^ P[0];
    e2 = ref_enc(KEY, w2) ^ P[1];
    config_iv(3'd4, 1'b0, w1);
    send(P[0], e1, 1'b1);
    send(P[1], e2, 1'b1);
    drain();
    config_iv(3'd7, 1'b0, '0);
    send(P[0], ECB_C[0], 1'b1);
    drain();
    config_iv(3'd4, 1'b0, IVC);
    for (int i = 0; i < 3; i++) send(P[i], CTR_C[i], 1'b0);
    @(negedge clk);
    chk("busy_before_reset", 128'(dut.state), 128'(BUSY));
    @(posedge clk); #1 rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_dout_valid", 128'(dout_valid_o), 128'd0);
    chk("mid_rst_state", 128'(dut.state), 128'(UNCFG));
    chk("mid_rst_din_ready", 128'(din_ready_o), 128'd0);
    chk("mid_rst_dout", dout_o, 128'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    load_key(KEY);
    config_iv(3'd0, 1'b0, '0);
    send(P[0], ECB_C[0], 1'b1);
    drain();
    repeat (40) @(negedge clk);
    chk("scoreboard_empty", 128'(sb.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/aes_mode_engine.md
# aes_mode_engine

Parametrised block-cipher mode engine: wraps the forward AES cipher core and implements ECB, CBC-encrypt, CFB-128 (encrypt/decrypt), OFB and CTR over 128-bit valid/ready streams. Mode, direction and IV are latched at configuration time. CTR and ECB blocks are pipelined through the core, up to `DEPTH` in flight. Feedback modes run one block at a time. It generalises `aes_ctr` and sits between the host data path and `aes_cipher`.

## Interface
- `KEY_SIZE`, from `aes_pkg` (128/192/256): key width.
- `CTR_WIDTH`, default 32: low IV bits incremented in CTR mode (1..128).
- `DEPTH`, default 4: maximum blocks in flight, which is also the plaintext FIFO depth (power of 2, ≥2).
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `key_i`  in  `KEY_SIZE`  cipher key.
- `key_valid_i`  in  1  key handshake valid.
- `key_ready_o`  out  1  passthrough of core `key_ready_o`.
- `mode_i`  in  3  `aes_pkg::mode_e`: ECB=0, CBC=1, CFB=2, OFB=3, CTR=4; sampled with IV.
- `decrypt_i`  in  1  CFB direction; sampled with IV; ignored in other modes.
- `iv_i`  in  128  IV / initial counter.
- `iv_valid_i`  in  1  config handshake valid.
- `iv_ready_o`  out  1  high in `UNCFG`/`IDLE`.
- `din_i`  in  128  input block.
- `din_valid_i`  in  1  input valid.
- `din_ready_o`  out  1  input ready.
- `dout_o`  out  128  result block.
- `dout_valid_o`  out  1  result valid.
- `dout_ready_i`  in  1  downstream ready.

## Operation
- **Chaining register V.** On `iv_valid_i && iv_ready_o`: V←`iv_i`, and mode and direction are latched. Mode values 5–7 are treated as ECB.
- **Per accepted block X.** The core input and the output are:
  - ECB: core input X; out = E(X).
  - CBC: core input X⊕V; out C = E(X⊕V); V←C.
  - CFB encrypt: core input V; out C = E(V)⊕X; V←C.
  - CFB decrypt: core input V; out E(V)⊕X; V←X.
  - OFB: core input V; out E(V)⊕X; V←E(V).
  - CTR: core input V; out E(V)⊕X; V←{V[127:CTR_WIDTH], V[CTR_WIDTH-1:0]+1}.
- **CTR counter.** The increment wraps mod 2^CTR_WIDTH; upper bits never change. V updates at input acceptance.
- **Plaintext FIFO.** X is pushed into the `DEPTH`-entry FIFO on acceptance. It is popped when the core result is moved into the output register.
- **FSM states.**
  - `UNCFG`: reset state; `din_ready_o`=0.
  - `IDLE`: configured, nothing in flight.
  - `BUSY`: in-flight count > 0.
- **FSM transitions.**
  - `UNCFG`→`IDLE` on config.
  - `IDLE`→`BUSY` on din accept.
  - `BUSY`→`IDLE` when the in-flight count reaches 0 and no din is accepted that cycle.
  - `IDLE` accepts re-configuration. In `BUSY`, `iv_valid_i` is not accepted (`iv_ready_o`=0).
- **`din_ready_o`** = state≠`UNCFG` && core din ready && FIFO not full && (mode∈{ECB,CTR} || in-flight==0).
- **Key load.** A new key may be loaded only in `UNCFG`/`IDLE`; key and config transfers never overlap data.
- **Reset.** Asserting reset at any time clears V, the FIFO, the counters and the output register, and returns to `UNCFG`. The core is reset by the same `rst_n`, so the key must be reloaded after reset.

## Timing
- **Reset values:** `dout_o`=0, `dout_valid_o`=0, `din_ready_o`=0, `iv_ready_o`=1. `key_ready_o` follows the core's reset value.
- **Output register:** a single stage. It loads when it is empty or `dout_ready_i`=1, and core `dout_ready_i` = that load condition.
- **Output stability:** `dout_o` holds stable while `dout_valid_o && !dout_ready_i`.
- **Latency:** core latency L + 1 cycle from din accept to `dout_valid_o`.
- **Throughput:** in ECB/CTR, one block per core issue slot. In feedback modes, one block per L+1 cycles; the next din is accepted in the cycle after the output handshake.
- **Simultaneous events:** FIFO push and pop in the same cycle keep the count unchanged. In-flight increment and decrement in the same cycle net to zero.

## Structure
- **`aes_pkg`:** `mode_e`, `KEY_SIZE`, `BLOCK_W=128`, and the state enum.
- **`aes_cipher`:** the existing forward core, instantiated once. No inverse cipher is needed, since all modes use E() only.
- **`aes_mode_fifo`:** sub-module holding the plaintext FIFO, parametrised by `DEPTH`, with count outputs.

## Test plan
All cases use SP800-38A, key 2b7e151628aed2a6abf7158809cf4f3c, P1=6bc1bee22e409f96e93d7e117393172a.
- **ECB:** load key, config ECB, P1 → 3ad77bb40d7a3660a89ecaf32466ef97.
- **CBC:** IV 000102…0f, P1 → 7649abac8119b246cee98e9b12e9197d. Four blocks match F.2.1; `din_ready_o` stays low while a block is in flight.
- **OFB / CFB:**
  - OFB IV 000102…0f, P1 → 3b3fd92eb72dad20333449f8e83cfb4a.
  - CFB encrypt gives the same first block.
  - CFB decrypt of that ciphertext → P1; four blocks match F.3.13 and F.3.14.
- **CTR, pipelined with backpressure:**
  - IV f0f1…feff, four blocks back-to-back, first output 874d6191b620e3261bef6864990db6ce.
  - Toggle `dout_ready_i` 50%; outputs stay in order and held stable while stalled.
- **CTR wrap:** `CTR_WIDTH`=32, IV …ffffffff → second counter = {IV[127:32], 00000000}. Check the second output against a reference model.
- **Reset mid-operation:** assert `rst_n`=0 during `BUSY` with 3 blocks in flight. Afterwards `dout_valid_o`=0, state is `UNCFG`, and no stale output appears after key and config reload.
